// File: rtl/imem_stream_loaded_pkg.sv
// imem_pkg: shared state encoding, index-width helper and opcode constants.
// Used by the instruction memory and by the decoder that consumes its words.
package imem_pkg;
  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b10000;
  localparam logic [31:0] NOP_INSN = 32'b0;
  function automatic int idx_w(int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/imem_stream_loaded_if.sv
// imem_stream_loaded_if: loader stream, reload and fetch bus of the instruction memory.
// slave = the memory; master = loader/fetch stage driving the requests.
interface imem_stream_loaded_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W = 9
);
  logic prog_valid;
  logic prog_ready;
  logic [DATA_W-1:0] prog_data;
  logic prog_last;
  logic reload;
  logic fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic fetch_valid;
  logic fetch_err;
  logic loaded;
  logic [LEN_W-1:0] prog_len;
  modport slave (
    input prog_valid, prog_data, prog_last, reload, fetch_en, fetch_addr,
    output prog_ready, fetch_data, fetch_valid, fetch_err, loaded, prog_len
  );
  modport master (
    output prog_valid, prog_data, prog_last, reload, fetch_en, fetch_addr,
    input prog_ready, fetch_data, fetch_valid, fetch_err, loaded, prog_len
  );
endinterface

// File: rtl/imem_stream_loaded_ram.sv
// imem_ram: DEPTH x DATA_W array, synchronous write and synchronous read (1R1W block RAM).
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata holds when re=0.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic clk,
  input  logic we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic re,
  input  logic [IDX_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_stream_loaded.sv
// imem_stream_loaded: stream-loaded instruction memory with registered, fault-checked fetch.
// Ports: clk, rst (sync, active high); bus (slave): prog_* loader stream, reload,
// fetch_en/fetch_addr request, fetch_data/fetch_valid/fetch_err response, loaded, prog_len.
module imem_stream_loaded
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic clk,
  input logic rst,
  imem_stream_loaded_if.slave bus
);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] wr_ptr;
  logic [LEN_W-1:0] len;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rdata;
  logic accept, rd_en, mis, oor, unl, nop_q, err_q, valid_q;
  assign bus.prog_ready = (state == S_LOAD) && !rst;
  assign accept = bus.prog_valid && bus.prog_ready;
  assign rd_en = (state == S_RUN) && bus.fetch_en && !bus.reload;
  assign idx = bus.fetch_addr >> 2;
  assign mis = |bus.fetch_addr[1:0];
  // Full-width compare so high addresses never alias back into the array.
  assign oor = idx >= ADDR_W'(DEPTH);
  assign unl = idx >= ADDR_W'(len);
  always_comb begin
    state_nx = state;
    if (state == S_LOAD)
      state_nx = accept && (bus.prog_last || wr_ptr == IDX_W'(DEPTH - 1)) ? S_RUN : S_LOAD;
    else
      state_nx = bus.reload ? S_LOAD : S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      wr_ptr <= '0;
      len <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      nop_q <= 1'b1;
    end else begin
      state <= state_nx;
      valid_q <= rd_en;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        len <= len + 1'b1;
      end
      if (state == S_RUN && bus.reload) begin
        wr_ptr <= '0;
        len <= '0;
      end
      if (rd_en) begin
        nop_q <= mis | oor | unl;
        err_q <= mis | oor;
      end
    end
  end
  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk(clk),
    .we(accept),
    .waddr(wr_ptr),
    .wdata(bus.prog_data),
    .re(rd_en),
    .raddr(idx[IDX_W-1:0]),
    .rdata(rdata)
  );
  // Fault selection is registered with the read, so the NOP mux sits after the RAM output.
  assign bus.fetch_data = nop_q ? NOP_WORD : rdata;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_err = err_q;
  assign bus.loaded = state == S_RUN;
  assign bus.prog_len = len;
endmodule

// File: tb/tb_imem_stream_loaded.sv
// tb_imem_stream_loaded: scoreboard bench for a DEPTH=256 and a DEPTH=8 instance.
module tb_imem_stream_loaded;
  localparam logic [31:0] NOP0 = 32'h0;
  localparam logic [31:0] NOP1 = 32'h13;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  imem_stream_loaded_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(9)) b0 ();
  imem_stream_loaded_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(4)) b1 ();
  imem_stream_loaded #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .NOP_WORD(NOP0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  imem_stream_loaded #(.DATA_W(32), .DEPTH(8), .ADDR_W(32), .NOP_WORD(NOP1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  logic [1:0] pv = 0, pl = 0, rl = 0, fe = 0;
  logic [31:0] pd [2] = '{0, 0};
  logic [31:0] fa [2] = '{0, 0};
  assign b0.prog_valid = pv[0];
  assign b0.prog_last = pl[0];
  assign b0.prog_data = pd[0];
  assign b0.reload = rl[0];
  assign b0.fetch_en = fe[0];
  assign b0.fetch_addr = fa[0];
  assign b1.prog_valid = pv[1];
  assign b1.prog_last = pl[1];
  assign b1.prog_data = pd[1];
  assign b1.reload = rl[1];
  assign b1.fetch_en = fe[1];
  assign b1.fetch_addr = fa[1];
  wire [1:0] pr = {b1.prog_ready, b0.prog_ready};
  wire [1:0] ld = {b1.loaded, b0.loaded};
  wire [1:0] fv = {b1.fetch_valid, b0.fetch_valid};
  function automatic logic [31:0] fdat(int w);
    return w != 0 ? b1.fetch_data : b0.fetch_data;
  endfunction
  function automatic logic [31:0] flen(int w);
    return w != 0 ? 32'(b1.prog_len) : 32'(b0.prog_len);
  endfunction
  typedef struct packed {logic [31:0] d; logic e;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int errs = 0;
  int checks = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic spurious(string name);
    checks++;
    errs++;
    $display("FAIL %s: fetch_valid=1 with no fetch outstanding", name);
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (b0.fetch_valid) begin
      if (q0.size() == 0) spurious("u0 valid");
      else begin
        x = q0.pop_front();
        chk("u0 fetch_data", b0.fetch_data, x.d);
        chk("u0 fetch_err", 32'(b0.fetch_err), 32'(x.e));
      end
    end
    if (b1.fetch_valid) begin
      if (q1.size() == 0) spurious("u1 valid");
      else begin
        x = q1.pop_front();
        chk("u1 fetch_data", b1.fetch_data, x.d);
        chk("u1 fetch_err", 32'(b1.fetch_err), 32'(x.e));
      end
    end
  end
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) sync();
  endtask
  task automatic send(int w, logic [31:0] d, logic l);
    bit ok = 0;
    pv[w] = 1;
    pd[w] = d;
    pl[w] = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (pr[w]) ok = 1;
      sync();
    end
    pv[w] = 0;
    pl[w] = 0;
    chk("word accepted", 32'(ok), 1);
  endtask
  task automatic fetch(int w, logic [31:0] a, logic [31:0] d, logic e);
    fe[w] = 1;
    fa[w] = a;
    if (w != 0) q1.push_back('{d, e});
    else q0.push_back('{d, e});
    sync();
    fe[w] = 0;
  endtask
  task automatic pulse_reload(int w);
    rl[w] = 1;
    sync();
    rl[w] = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready held low in rst", 32'(pr), 0);
    sync();
    rst = 0;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("reset ready", 32'(pr[w]), 1);
      chk("reset loaded", 32'(ld[w]), 0);
      chk("reset prog_len", flen(w), 0);
      chk("reset fetch_valid", 32'(fv[w]), 0);
      chk("reset fetch_data", fdat(w), w != 0 ? NOP1 : NOP0);
    end
    sync();
    fe[0] = 1;
    fa[0] = 0;
    rl[0] = 1;
    sync();
    fe[0] = 0;
    rl[0] = 0;
    @(negedge clk);
    chk("fetch ignored in LOAD", 32'(fv[0]), 0);
    chk("reload ignored in LOAD", 32'(pr[0]), 1);
    sync();
    for (int i = 0; i < 9; i++) begin
      send(0, 32'hB000_0000 - 32'(i) * 32'h0600_0000, i == 8);
      if (i == 7) begin
        @(negedge clk);
        chk("not loaded before last", 32'(ld[0]), 0);
        sync();
      end
    end
    @(negedge clk);
    chk("loaded after last", 32'(ld[0]), 1);
    chk("prog_len 9", flen(0), 9);
    chk("ready low in RUN", 32'(pr[0]), 0);
    sync();
    for (int i = 0; i < 9; i++) fetch(0, 32'(i * 4), 32'hB000_0000 - 32'(i) * 32'h0600_0000, 0);
    fetch(0, 36, NOP0, 0);
    fetch(0, 32, 32'h8000_0000, 0);
    idle(2);
    @(negedge clk);
    chk("fetch_valid drops", 32'(fv[0]), 0);
    chk("fetch_data holds", fdat(0), 32'h8000_0000);
    sync();
    rl[0] = 1;
    fe[0] = 1;
    fa[0] = 0;
    sync();
    rl[0] = 0;
    fe[0] = 0;
    @(negedge clk);
    chk("reload drops fetch", 32'(fv[0]), 0);
    chk("reload ready", 32'(pr[0]), 1);
    chk("reload prog_len", flen(0), 0);
    chk("reload loaded", 32'(ld[0]), 0);
    sync();
    for (int i = 0; i < 5; i++) begin
      send(0, 32'h1000_0000 + 32'(i), i == 4);
      @(negedge clk);
      chk("throttled prog_len", flen(0), 32'(i + 1));
      sync();
    end
    chk("throttled loaded", 32'(ld[0]), 1);
    for (int i = 0; i < 5; i++) fetch(0, 32'(i * 4), 32'h1000_0000 + 32'(i), 0);
    fetch(0, 20, NOP0, 0);
    pulse_reload(0);
    for (int i = 0; i < 4; i++) send(0, 32'hC000_0000 + 32'(i), i == 3);
    fetch(0, 32'h6, NOP0, 1);
    fetch(0, 32'd1024, NOP0, 1);
    fetch(0, 32'h10, NOP0, 0);
    fetch(0, 32'hC, 32'hC000_0003, 0);
    fetch(0, 32'h8000_0000, NOP0, 1);
    fetch(0, 32'h401, NOP0, 1);
    fetch(0, 32'h2, NOP0, 1);
    fetch(0, 32'h4, 32'hC000_0001, 0);
    idle(2);
    pulse_reload(0);
    for (int i = 0; i < 3; i++) send(0, 32'hF000_0000 + 32'(i), 0);
    rst = 1;
    sync();
    rst = 0;
    @(negedge clk);
    chk("rst prog_len", flen(0), 0);
    chk("rst fetch_valid", 32'(fv[0]), 0);
    chk("rst ready", 32'(pr[0]), 1);
    chk("rst loaded", 32'(ld[0]), 0);
    chk("rst fetch_data", fdat(0), NOP0);
    sync();
    send(0, 32'hD000_0000, 1);
    fetch(0, 8, NOP0, 0);
    fetch(0, 0, 32'hD000_0000, 0);
    idle(2);
    for (int i = 0; i < 8; i++) send(1, 32'hE000_0000 + 32'(i), 0);
    @(negedge clk);
    chk("full loaded", 32'(ld[1]), 1);
    chk("full ready low", 32'(pr[1]), 0);
    chk("full prog_len", flen(1), 8);
    sync();
    pv[1] = 1;
    pd[1] = 32'hE000_0008;
    idle(3);
    pv[1] = 0;
    @(negedge clk);
    chk("extra words refused", flen(1), 8);
    chk("still loaded", 32'(ld[1]), 1);
    sync();
    fetch(1, 28, 32'hE000_0007, 0);
    fetch(1, 32, NOP1, 1);
    fetch(1, 0, 32'hE000_0000, 0);
    fetch(1, 29, NOP1, 1);
    idle(3);
    chk("u0 queue drained", 32'(q0.size()), 0);
    chk("u1 queue drained", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/imem_stream_loaded.md
Name: imem_stream_loaded

Overview:
- Parametrised instruction memory, successor to the fixed hard-coded program ROM. It sits between the fetch stage (PC) and a program loader such as a UART or bench streamer.
- After reset it accepts the program as a valid/ready word stream, then switches to RUN and serves registered fetches at byte addresses.
- Adds alignment/range fault reporting, NOP fill beyond the loaded length, and a reload path without a full reset.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 256, number of instruction words (any value >= 2)
ADDR_W, 32, fetch byte-address width
NOP_WORD, 32'b0, word returned for unloaded, out-of-range or misaligned fetches

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
prog_valid  in  1  loader presents prog_data
prog_ready  out  1  block accepts a word this cycle
prog_data  in  DATA_W  instruction word to store
prog_last  in  1  marks final word of program (qualified by prog_valid)
reload  in  1  1-cycle pulse in RUN: return to LOAD
fetch_en  in  1  fetch request
fetch_addr  in  ADDR_W  byte address (PC)
fetch_data  out  DATA_W  registered instruction
fetch_valid  out  1  fetch_data valid this cycle
fetch_err  out  1  fault flag, qualified by fetch_valid
loaded  out  1  1 in RUN state
prog_len  out  $clog2(DEPTH+1)  number of words loaded

Behaviour:
- Reset (rst high at posedge):
  - Outputs and state: state=LOAD, wr_ptr=0, prog_len=0, fetch_data=NOP_WORD, fetch_valid=0, fetch_err=0, loaded=0.
  - Memory array is not cleared.
- prog_ready = (state==LOAD) && !rst. It is combinational from state only and never depends on prog_valid.
- LOAD state:
  - Handshake: a word is accepted when prog_valid && prog_ready.
  - On accept: mem[wr_ptr] <= prog_data, wr_ptr++, prog_len++.
  - Accepted with prog_last=1 -> next state RUN.
  - Accept when wr_ptr==DEPTH-1 -> next state RUN regardless of prog_last. Loading is full; further words are never accepted.
  - prog_valid without prog_ready: no effect. The loader must hold data stable.
  - fetch_en is ignored: fetch_valid=0, fetch_data holds.
  - reload is ignored.
- RUN state:
  - prog_ready=0. prog_* inputs are ignored.
  - fetch_en=1 at cycle N -> fetch_valid=1 at cycle N+1 (latency 1).
  - fetch_en=0 -> fetch_valid=0 next cycle; fetch_data holds its last value.
  - idx = fetch_addr >> 2.
  - Fault priority, highest first:
    1. misaligned (fetch_addr[1:0]!=0) -> fetch_data=NOP_WORD, fetch_err=1
    2. idx >= DEPTH -> NOP_WORD, fetch_err=1 (compare the full upper address, no wrap)
    3. idx >= prog_len -> NOP_WORD, fetch_err=0 (unloaded region reads as NOP)
    4. otherwise fetch_data=mem[idx], fetch_err=0
  - reload=1 -> next state LOAD, wr_ptr=0, prog_len=0, fetch_valid=0.
  - reload and fetch_en in the same cycle: reload wins and the fetch is dropped.
- Reset mid-LOAD or mid-RUN: full return to reset values. Stale array contents are masked by prog_len=0.
- Memory: single write port (LOAD) and single read port (RUN) are never active together. The array is inferable as a 1R1W block RAM.

Decomposition:
- Shared package imem_pkg:
  - state encoding: S_LOAD=1'b0, S_RUN=1'b1
  - IDX_W = $clog2(DEPTH) helper
  - NOP/HALT opcode constants shared with the decoder (halt = opcode 5'b10000)
- One sub-module, imem_ram: a parametrised DEPTH x DATA_W synchronous-read, synchronous-write array.
- The FSM, pointer, fault logic and output registers stay in the top level.

Test Plan:
- Load 9 words (0xB0000000 ... 0x80000000) with prog_last on the 9th -> prog_len=9, loaded=1 the cycle after; fetch addr 0,4,...,32 returns the words in order, each 1 cycle after fetch_en, fetch_err=0.
- Loader throttling: prog_valid toggled 1/0 for 5 words, prog_last on word 5 -> exactly 5 writes, prog_len=5; no writes while prog_valid=0.
- Faults after a 4-word load:
  - addr 0x6 -> NOP_WORD, err=1
  - addr DEPTH*4 -> NOP_WORD, err=1
  - addr 0x10 (idx 4 >= prog_len) -> NOP_WORD, err=0
- Full load: DEPTH=8, stream 10 words without prog_last -> exactly 8 accepted, prog_ready drops after the 8th, RUN entered, addr 28 returns word 8.
- reload in RUN with simultaneous fetch_en -> fetch_valid=0, prog_ready=1 next cycle, prog_len=0; reload 2 new words and confirm addr 0 returns the new word 0.
- rst asserted mid-LOAD after 3 words -> prog_len=0, fetch_valid=0, state LOAD; after a 1-word reload, fetch addr 8 returns NOP_WORD with err=0.
